// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: buffers one input vector, then broadcasts it to the neuron array for numWeight back-to-back cycles.
// Optional counters under `LAYER_SEQ_PERF_EN; in_ready (high only while loading) is the sole backpressure, RUN never stalls.
module layer_seq_ctrl #(
  parameter int numWeight    = 784,
  parameter int dataWidth    = 16,
  parameter int addressWidth = $clog2(numWeight)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [dataWidth-1:0] in_data,
  output logic                 in_ready,
  output logic                 freeze,
  output logic                 pause,
  output logic [dataWidth-1:0] myinput,
  output logic                 busy,
  output logic                 result_valid
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]          perf_runs,
  output logic [31:0]          perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
  localparam logic [addressWidth-1:0] ONE_IDX  = addressWidth'(1);

  state_t                  r_state;
  state_t                  w_next;
  logic [addressWidth-1:0] r_ld_idx;
  logic [addressWidth-1:0] r_run_idx;
  logic [dataWidth-1:0]    r_buf [numWeight];

  logic w_beat;
  logic w_ld_last;
  logic w_run_last;
  logic w_enter_load;
  logic w_enter_run;

  assign w_beat       = (r_state == S_LOAD) && in_valid;
  assign w_ld_last    = (r_ld_idx == LAST_IDX);
  assign w_run_last   = (r_run_idx == LAST_IDX);
  assign w_enter_load = (r_state != S_LOAD) && (w_next == S_LOAD);
  assign w_enter_run  = (r_state != S_RUN) && (w_next == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs decode from state only, so an async reset forces freeze/pause high at once.
  always_comb begin
    w_next       = r_state;
    freeze       = 1'b1;
    pause        = 1'b1;
    in_ready     = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    myinput      = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && w_ld_last) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        freeze  = 1'b0;
        pause   = 1'b0;
        busy    = 1'b1;
        myinput = r_buf[r_run_idx];
        if (w_run_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        result_valid = 1'b1;
        w_next       = start ? S_LOAD : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Indices restart on state entry and park on their last value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_idx  <= '0;
      r_run_idx <= '0;
    end else begin
      if (w_enter_load) begin
        r_ld_idx <= '0;
      end else if (w_beat && !w_ld_last) begin
        r_ld_idx <= r_ld_idx + ONE_IDX;
      end
      if (w_enter_run) begin
        r_run_idx <= '0;
      end else if ((r_state == S_RUN) && !w_run_last) begin
        r_run_idx <= r_run_idx + ONE_IDX;
      end
    end
  end

  // Sample buffer has no reset: it is only read after a complete load.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_buf[r_ld_idx] <= in_data;
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  logic [31:0] r_perf_runs;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_runs  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (r_state == S_DONE) begin
        r_perf_runs <= r_perf_runs + 32'd1;
      end
      if ((r_state == S_LOAD) && !in_valid) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_runs  = r_perf_runs;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: per-vector transaction model plus a behavioural neuron checked against a dot-product golden.
module tb_layer_seq_ctrl;
  localparam int NW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          freeze;
  logic          pause;
  logic [DW-1:0] myinput;
  logic          busy;
  logic          result_valid;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]   perf_runs;
  logic [31:0]   perf_stall;
`endif

  int n_checks = 0;
  int n_fail = 0;
  int exp_runs = 0;
  int exp_stall = 0;

  logic [DW-1:0] w [NW];
  logic [DW-1:0] bias;
  longint        nsum = 0;
  int            nidx = 0;

  always #5 clk = ~clk;

  layer_seq_ctrl #(.numWeight(NW), .dataWidth(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .freeze       (freeze),
    .pause        (pause),
    .myinput      (myinput),
    .busy         (busy),
    .result_valid (result_valid)
`ifdef LAYER_SEQ_PERF_EN
    ,
    .perf_runs    (perf_runs),
    .perf_stall   (perf_stall)
`endif
  );

  // Behavioural neuron: clears while frozen, accumulates while running, bias on the last product.
  always @(posedge clk) begin
    if (freeze) begin
      nidx <= 0;
    end else if (nidx < NW) begin
      nsum <= (nidx == 0 ? 64'sd0 : nsum)
              + longint'($signed(myinput)) * longint'($signed(w[nidx]))
              + (nidx == NW - 1 ? longint'($signed(bias)) : 64'sd0);
      nidx <= nidx + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint golden(input logic [DW-1:0] v [NW]);
    longint s = longint'($signed(bias));
    for (int k = 0; k < NW; k++) begin
      s += longint'($signed(v[k])) * longint'($signed(w[k]));
    end
    return s;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".freeze"}, 64'(freeze), 64'd1);
    check({tag, ".pause"}, 64'(pause), 64'd1);
    check({tag, ".in_ready"}, 64'(in_ready), 64'd0);
    check({tag, ".busy"}, 64'(busy), 64'd0);
    check({tag, ".result_valid"}, 64'(result_valid), 64'd0);
    check({tag, ".myinput"}, 64'(myinput), 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in the first LOAD cycle; returns in the first RUN cycle.
  task automatic load_vec(input logic [DW-1:0] v [NW], input int gaps [NW]);
    for (int k = 0; k < NW; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        check("load_gap.in_ready", 64'(in_ready), 64'd1);
        check("load_gap.busy", 64'(busy), 64'd1);
        check("load_gap.freeze", 64'(freeze), 64'd1);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        @(negedge clk);
      end
      check("load_beat.in_ready", 64'(in_ready), 64'd1);
      check("load_beat.result_valid", 64'(result_valid), 64'd0);
      in_valid = 1'b1;
      in_data  = v[k];
      exp_stall += gaps[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_phase(input logic [DW-1:0] v [NW], input int start_k, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      check("run.freeze", 64'(freeze), 64'd0);
      check("run.pause", 64'(pause), 64'd0);
      check("run.busy", 64'(busy), 64'd1);
      check("run.in_ready", 64'(in_ready), 64'd0);
      check("run.result_valid", 64'(result_valid), 64'd0);
      check("run.myinput", 64'(myinput), 64'(v[k]));
      in_valid = 1'b1;
      in_data  = ~v[NW-1];
      start    = (k == start_k);
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic done_phase(input logic [DW-1:0] v [NW], input bit start_done);
    check("done.result_valid", 64'(result_valid), 64'd1);
    check("done.freeze", 64'(freeze), 64'd1);
    check("done.pause", 64'(pause), 64'd1);
    check("done.busy", 64'(busy), 64'd0);
    check("done.in_ready", 64'(in_ready), 64'd0);
    check("done.neuron_sum", 64'(nsum), 64'(golden(v)));
    start = start_done;
    @(negedge clk);
    start = 1'b0;
    exp_runs++;
    check("post_done.in_ready", 64'(in_ready), 64'(start_done));
    check("post_done.busy", 64'(busy), 64'(start_done));
    check("post_done.result_valid", 64'(result_valid), 64'd0);
`ifdef LAYER_SEQ_PERF_EN
    check("perf_runs", 64'(perf_runs), 64'(exp_runs));
    check("perf_stall", 64'(perf_stall), 64'(exp_stall));
`endif
  endtask

  initial begin
    logic [DW-1:0] v [NW];
    int            nogap [NW];
    int            gaps [NW];

    for (int k = 0; k < NW; k++) begin
      w[k]     = DW'($urandom);
      nogap[k] = 0;
    end
    bias = DW'($urandom);

    // Reset state, then quiet idle with junk on the input bus.
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      @(negedge clk);
      check_idle("idle");
    end
    in_valid = 1'b0;

    // Back-to-back beats 1,2,3,4.
    v = '{16'd1, 16'd2, 16'd3, 16'd4};
    pulse_start();
    load_vec(v, nogap);
    run_phase(v, -1, NW);
    done_phase(v, 1'b0);
    @(negedge clk);
    check_idle("idle_after_done");

    // Same vector with beats on cycles 0,3,4,7; start during RUN ignored, start in DONE chains.
    gaps = '{0, 2, 0, 2};
    pulse_start();
    load_vec(v, gaps);
    run_phase(v, 1, NW);
    done_phase(v, 1'b1);

    // Already in LOAD: random vector with random gaps.
    for (int k = 0; k < NW; k++) begin
      v[k]    = DW'($urandom);
      gaps[k] = $urandom_range(0, 2);
    end
    load_vec(v, gaps);
    run_phase(v, -1, NW);
    done_phase(v, 1'b0);

    // Reset in RUN cycle 2 aborts at once.
    for (int k = 0; k < NW; k++) v[k] = DW'($urandom);
    pulse_start();
    load_vec(v, nogap);
    run_phase(v, -1, 2);
    check("abort.myinput_before", 64'(myinput), 64'(v[2]));
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    exp_runs  = 0;
    exp_stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_abort");
`ifdef LAYER_SEQ_PERF_EN
    check("post_abort.perf_runs", 64'(perf_runs), 64'd0);
    check("post_abort.perf_stall", 64'(perf_stall), 64'd0);
`endif

    // Fresh vectors after the abort, neuron sum checked including bias.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NW; k++) begin
        v[k]    = DW'($urandom);
        gaps[k] = (r == 0) ? 0 : $urandom_range(0, 3);
      end
      pulse_start();
      load_vec(v, gaps);
      run_phase(v, -1, NW);
      done_phase(v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
